tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive side of the 2:1 mux chain: a time-division demultiplexer that splits a serialized word stream back into NCH parallel channels.
- Slot 0 of each frame is flagged by in_sof. Each following valid word goes to the next channel in order.
- Per-channel output registers hold their last value. Per-channel strobes mark each update, and one strobe marks frame completion.
- Sits downstream of a cascaded-mux serializer.

Parameters:
- NCH, 4, number of channels/slots per frame (>=1)
- DW, 8, data word width in bits
- SW, $clog2(NCH) with a minimum of 1, slot index width (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_sof  input  1  start of frame: current word is slot 0; ignored unless in_valid
- in_data  input  DW  serialized data word
- out_data  output  NCH*DW  channel registers; channel i occupies bits [i*DW +: DW]
- out_valid  output  NCH  one-cycle pulse, bit i set when channel i was written
- frame_done  output  1  one-cycle pulse when slot NCH-1 is written
- sync_err  output  1  one-cycle pulse on framing violation
- slot  output  SW  index the next accepted word will be written to (debug)
- locked  output  1  high in RUN state

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot=0. out_data, out_valid, frame_done, sync_err and locked are all 0.
- All outputs are registered. Write latency is 1 cycle: a word accepted at edge N appears on out_data/out_valid after edge N.
- A cycle with in_valid=0 changes nothing except clearing the pulse outputs. Gaps of any length between words are legal.
- HUNT state:
  - in_valid & in_sof: write ch0, pulse out_valid[0]. If NCH==1, also pulse frame_done, stay HUNT, slot=0. Otherwise go RUN, slot=1.
  - in_valid & !in_sof: word discarded, no strobes, no sync_err, stay HUNT.
- RUN state:
  - in_valid & !in_sof: write ch[slot], pulse out_valid[slot].
    - If slot==NCH-1: pulse frame_done, slot=0, go HUNT. The next frame must begin with in_sof.
    - Otherwise slot=slot+1.
  - in_valid & in_sof (premature start): pulse sync_err, then treat the word as a new frame: write ch0, pulse out_valid[0], slot=1 (NCH==1 is unreachable here). Channels not reached in the aborted frame keep their stale values. No frame_done is raised for the aborted frame.
- At most one out_valid bit is set per cycle. frame_done is always coincident with out_valid[NCH-1].
- Pulse outputs (out_valid, frame_done, sync_err) default to 0 each cycle unless set by a write.
- Unwritten channels hold their value indefinitely. out_data is never cleared except by reset.
- locked = (state==RUN). slot is always <NCH and never wraps via overflow; it wraps only through the explicit reset to 0.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and the next frame needs in_sof.

Test Plan:
1. NCH=4, DW=8. After reset, send sof+0x11, then 0x22, 0x33, 0x44 back-to-back.
   -> out_valid = 0001, 0010, 0100, 1000 on consecutive cycles; frame_done coincident with 1000; out_data = 0x44332211; locked falls after the last word.
2. Words 0xAA, 0xBB without sof after reset.
   -> no strobes, sync_err=0, out_data stays 0, slot=0.
3. Frame sof+0x01, 0x02 (2-cycle gap, in_valid=0), 0x03, 0x04.
   -> same result as a gapless frame; out_data = 0x04030201; frame_done exactly once.
4. sof+0x10, 0x20, then sof+0x30, 0x40, 0x50, 0x60.
   -> sync_err pulses with the out_valid[0] for 0x30; final out_data = 0x60504030; exactly one frame_done.
5. rst_n low for 1 cycle after sof+0x77, 0x88.
   -> all outputs 0 immediately; the following 0x99 without sof is discarded.
6. NCH=1, DW=4: sof+0x5.
   -> out_valid[0] and frame_done pulse together; out_data = 0x5; locked stays 0.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive-side TDM demultiplexer.
// A frame starts with an in_sof-flagged word in slot 0. Each following valid
// word fills the next channel register. Per-channel strobes mark each write,
// frame_done marks the last slot, and sync_err flags an early start of frame.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DW-1:0]     in_data,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic [SW-1:0]     slot,
  output logic              locked
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [NCH-1:0]   slot_hot;
  logic [NCH-1:0]   wr_en_d;
  logic [NCH-1:0]   out_valid_q;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic             locked_q;

  // One-hot decode of the current slot, used as the per-channel write select.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_slot_hot
    assign slot_hot[gi] = (slot_q == SW'(gi));
  end

  // Next-state decode: which channel is written, where the slot pointer goes,
  // and which pulses fire for the word presented this cycle.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    wr_en_d      = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A start of frame always lands in channel 0; seen while still in
        // RUN it means the previous frame was cut short.
        wr_en_d[0] = 1'b1;
        sync_err_d = (state_q == RUN);
        if (NCH == 1) begin
          frame_done_d = 1'b1;
          state_d      = HUNT;
          slot_d       = '0;
        end else begin
          state_d = RUN;
          slot_d  = SW'(1);
        end
      end else if (state_q == RUN) begin
        wr_en_d = slot_hot;
        if (slot_q == LAST_SLOT) begin
          // Last slot closes the frame; the next one must begin with in_sof.
          frame_done_d = 1'b1;
          state_d      = HUNT;
          slot_d       = '0;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      // Words without in_sof while hunting are silently discarded.
    end
  end

  // Framing FSM with registered pulse and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_valid_q  <= wr_en_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= (state_d == RUN);
    end
  end

  // Per-channel holding registers; a channel only changes when it is written.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic [DW-1:0] ch_q;

    // Capture the incoming word when this channel is selected.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ch_q <= '0;
      end else if (wr_en_d[gi]) begin
        ch_q <= in_data;
      end
    end

    assign out_data[gi*DW +: DW] = ch_q;
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign slot       = slot_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: a 4-channel instance driven through a
// scoreboard of expected per-cycle outputs, plus a 1-channel instance.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_sof;
  logic [DW-1:0]    in_data;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic             frame_done;
  logic             sync_err;
  logic [1:0]       slot;
  logic             locked;

  logic             v1, s1;
  logic [3:0]       d1;
  logic [3:0]       od1;
  logic [0:0]       ov1;
  logic             fd1, se1, lk1;
  logic [0:0]       sl1;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int se_cnt = 0;

  typedef struct packed {
    logic [3:0]  ov;
    logic        fd;
    logic        se;
    logic [31:0] data;
    logic        lk;
    logic [1:0]  sl;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic        m_run;
  int          m_slot;
  logic [31:0] m_data;

  tdm_demux #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .frame_done(frame_done), .sync_err(sync_err), .slot(slot), .locked(locked)
  );

  tdm_demux #(.NCH(1), .DW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_sof(s1),
    .in_data(d1), .out_data(od1), .out_valid(ov1),
    .frame_done(fd1), .sync_err(se1), .slot(sl1), .locked(lk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_slot = 0;
    m_data = '0;
  endtask

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] d);
    exp_t e;
    exp_t g;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    e.ov = '0;
    e.fd = 1'b0;
    e.se = 1'b0;
    if (v) begin
      if (s) begin
        e.se = m_run;
        m_data[7:0] = d;
        e.ov = 4'b0001;
        m_run = 1'b1;
        m_slot = 1;
      end else if (m_run) begin
        m_data[m_slot*8 +: 8] = d;
        e.ov = 4'b0001 << m_slot;
        if (m_slot == 3) begin
          e.fd = 1'b1;
          m_slot = 0;
          m_run = 1'b0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
    e.data = m_data;
    e.lk   = m_run;
    e.sl   = 2'(m_slot);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    $display("txn v=%0b sof=%0b d=%02h -> ov=%b fd=%0b se=%0b data=%08h lk=%0b slot=%0d",
             v, s, d, out_valid, frame_done, sync_err, out_data, locked, slot);
    check("out_valid", 64'(out_valid), 64'(g.ov));
    check("frame_done", 64'(frame_done), 64'(g.fd));
    check("sync_err", 64'(sync_err), 64'(g.se));
    check("out_data", 64'(out_data), 64'(g.data));
    check("locked", 64'(locked), 64'(g.lk));
    check("slot", 64'(slot), 64'(g.sl));
    fd_cnt += int'(frame_done);
    se_cnt += int'(sync_err);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 64'(out_data), 64'h0);
    check({tag, "_ov"}, 64'(out_valid), 64'h0);
    check({tag, "_fd"}, 64'(frame_done), 64'h0);
    check({tag, "_se"}, 64'(sync_err), 64'h0);
    check({tag, "_lk"}, 64'(locked), 64'h0);
    check({tag, "_slot"}, 64'(slot), 64'h0);
  endtask

  // Assert reset mid-cycle (checks async clear), hold over one edge, release.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    v1 = 1'b0; s1 = 1'b0; d1 = '0;
    model_reset();
    #3;
    do_reset("reset");
    check("reset1_data", 64'(od1), 64'h0);
    check("reset1_lk", 64'(lk1), 64'h0);

    // 1: back-to-back frame
    cycle(1, 1, 8'h11);
    cycle(1, 0, 8'h22);
    cycle(1, 0, 8'h33);
    fd_cnt = 0;
    cycle(1, 0, 8'h44);
    check("t1_data", 64'(out_data), 64'h44332211);
    check("t1_fd", 64'(fd_cnt), 64'd1);
    check("t1_unlocked", 64'(locked), 64'h0);
    cycle(0, 0, 8'h00);
    check("t1_fd_clear", 64'(frame_done), 64'h0);

    // 2: words without sof after reset are discarded
    do_reset("t2_rst");
    cycle(1, 0, 8'hAA);
    cycle(1, 0, 8'hBB);
    check("t2_data", 64'(out_data), 64'h0);
    check("t2_slot", 64'(slot), 64'h0);

    // 3: frame with a gap
    fd_cnt = 0;
    cycle(1, 1, 8'h01);
    cycle(1, 0, 8'h02);
    cycle(0, 0, 8'hEE);
    cycle(0, 0, 8'hEE);
    cycle(1, 0, 8'h03);
    cycle(1, 0, 8'h04);
    cycle(0, 0, 8'h00);
    check("t3_data", 64'(out_data), 64'h04030201);
    check("t3_fd_cnt", 64'(fd_cnt), 64'd1);

    // 4: premature sof
    fd_cnt = 0;
    se_cnt = 0;
    cycle(1, 1, 8'h10);
    cycle(1, 0, 8'h20);
    cycle(1, 1, 8'h30);
    check("t4_se_pulse", 64'(sync_err), 64'h1);
    check("t4_ov0", 64'(out_valid), 64'h1);
    cycle(1, 0, 8'h40);
    cycle(1, 0, 8'h50);
    cycle(1, 0, 8'h60);
    cycle(0, 0, 8'h00);
    check("t4_data", 64'(out_data), 64'h60504030);
    check("t4_fd_cnt", 64'(fd_cnt), 64'd1);
    check("t4_se_cnt", 64'(se_cnt), 64'd1);

    // 5: reset mid-frame
    cycle(1, 1, 8'h77);
    cycle(1, 0, 8'h88);
    do_reset("t5_rst");
    cycle(1, 0, 8'h99);
    check("t5_data", 64'(out_data), 64'h0);

    // Random traffic through the scoreboard
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 5) == 0, 8'($urandom));
    end

    // 6: single-channel instance
    v1 = 1'b1; s1 = 1'b1; d1 = 4'h5;
    @(posedge clk);
    #1;
    v1 = 1'b0; s1 = 1'b0;
    $display("txn1 sof d=5 -> ov=%b fd=%0b data=%0h lk=%0b", ov1, fd1, od1, lk1);
    check("t6_ov", 64'(ov1), 64'h1);
    check("t6_fd", 64'(fd1), 64'h1);
    check("t6_data", 64'(od1), 64'h5);
    check("t6_lk", 64'(lk1), 64'h0);
    check("t6_slot", 64'(sl1), 64'h0);
    v1 = 1'b1; s1 = 1'b1; d1 = 4'hA;
    @(posedge clk);
    #1;
    v1 = 1'b0; s1 = 1'b0;
    check("t6_se", 64'(se1), 64'h0);
    check("t6_data2", 64'(od1), 64'hA);
    @(posedge clk);
    #1;
    check("t6_ov_clear", 64'(ov1), 64'h0);
    check("t6_fd_clear", 64'(fd1), 64'h0);
    check("t6_hold", 64'(od1), 64'hA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
